bcd_timer_ctrl: RTL and testbench
=================================

BCD_TIMER_CTRL -- requirements
Module: bcd_timer_ctrl

Interface
REQ-001 Parameter: NDIG, default 4, number of cascaded BCD digits (legal 1..8).
REQ-002 Port: clk  in  1  single system clock; all state updates on rising edge.
REQ-003 Port: clr  in  1  reset, asynchronous, active-high.
REQ-004 Port: tick  in  1  one-cycle count-step strobe from the clock divider.
REQ-005 Port: start  in  1  start/resume request, level sampled each clk.
REQ-006 Port: stop  in  1  pause/abort request, level sampled each clk.
REQ-007 Port: load  in  1  load preset request, level sampled each clk.
REQ-008 Port: up  in  1  direction, 1 = count up, 0 = count down.
REQ-009 Port: preset  in  4*NDIG  BCD preset; digit 0 is bits [3:0].
REQ-010 Port: q  out  4*NDIG  current BCD count, registered.
REQ-011 Port: state  out  2  FSM state: IDLE=0, RUN=1, PAUSE=2, DONE=3.
REQ-012 Port: running  out  1  high exactly when state==RUN.
REQ-013 Port: done  out  1  one-cycle pulse on entry to DONE.

Function
REQ-014 Terminal value: all digits 9 when dir=1; all digits 0 when dir=0.
REQ-015 dir register latched from up on every IDLE->RUN transition; up ignored otherwise.
REQ-016 IDLE input priority: load > start.
REQ-017 IDLE, load=1: q <= preset; any preset digit >9 loads as 9; state stays IDLE.
REQ-018 IDLE, start=1, load=0: latch dir. Go to DONE if q equals terminal for the new dir, else go to RUN.
REQ-019 RUN input priority: stop > tick; load and start are ignored.
REQ-020 RUN, stop=1: go to PAUSE with no step, even if tick=1 in the same cycle.
REQ-021 RUN, tick=1, stop=0: q steps by one decimal count.
REQ-022 Stepping rule: digit i steps only when every lower digit is 9 (dir=1) or 0 (dir=0). An up-step of digit 9 wraps to 0; a down-step of digit 0 wraps to 9.
REQ-023 RUN: if the stepped value equals terminal, go to DONE in the same edge; the terminal value is held in q.
REQ-024 RUN, tick=0, stop=0: q holds.
REQ-025 PAUSE input priority: load > stop > start.
REQ-026 PAUSE, load=1: q <= preset (clamped), go to IDLE.
REQ-027 PAUSE, stop=1: go to IDLE with q held.
REQ-028 PAUSE, start=1: go to RUN; dir unchanged.
REQ-029 PAUSE: tick ignored.
REQ-030 DONE input priority: load > stop; start and tick ignored.
REQ-031 DONE, load=1: q <= preset (clamped), go to IDLE.
REQ-032 DONE, stop=1: go to IDLE with q held.
REQ-033 done is a registered output: high in the first cycle of DONE, low otherwise, with no repeat while DONE persists.
REQ-034 q digits are always valid BCD (0..9); no other value is reachable.

Reset
REQ-035 clr=1 forces, asynchronously: q=0, state=IDLE, dir=1, done=0, running=0.
REQ-036 clr asserted mid-RUN discards any pending tick; after release the block waits in IDLE for start.
REQ-037 First functional edge is the first rising clk with clr=0.

Structure
REQ-038 Shared package holds the state encodings (IDLE, RUN, PAUSE, DONE), the BCD digit width (4), and the BCD max digit (9).
REQ-039 One sub-module, bcd_digit, is instantiated NDIG times. It has clk, clr, step enable, dir, load, 4-bit d, 4-bit q, and a terminal flag (q==9 when up, q==0 when down).
REQ-040 The cascade enable for each digit is tick AND the terminal flags of all lower digits; the FSM lives in the top module.

Verification
REQ-041 Preset 0x0012, load, up=0, start, 12 ticks -> q=0x0000, DONE entered, done high for exactly 1 cycle.
REQ-042 Preset 0x0099, up=1, start, 1 tick -> q=0x0100; preset 0x0100, up=0, 1 tick -> q=0x0099.
REQ-043 RUN with tick and stop in the same cycle -> PAUSE, q unchanged; start -> RUN, next tick steps q.
REQ-044 Preset 0x9999, up=1, start -> DONE directly, done pulse, q=0x9999; preset 0x00A5 loads as 0x0095.
REQ-045 clr pulsed mid-RUN at q=0x0347, between clk edges -> q=0x0000 and state=IDLE immediately; ticks ignored until start.

Source files
------------

// File: rtl/bcd_timer_ctrl_pkg.sv
// Shared definitions for the BCD timer controller: FSM state encodings,
// BCD digit width, maximum BCD digit value and the preset clamp helper.
package bcd_timer_ctrl_pkg;

    localparam int unsigned BCD_W = 4;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Any non-BCD preset digit (A..F) is forced to 9.
    function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD counter digit with wrap-around up/down stepping and clamped load.
// Ports:
//   clk, clr  : clock, asynchronous active-high reset (q -> 0)
//   en        : step this digit by one on the next edge
//   dir       : 1 = count up, 0 = count down
//   load, d   : load clamped preset digit d (has priority over en)
//   q         : registered digit value, always 0..9
//   term_c    : combinational terminal flag (q==9 when up, q==0 when down)
module bcd_digit
    import bcd_timer_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [BCD_W-1:0] d,
    output logic [BCD_W-1:0] q,
    output logic             term_c
);

    // Digit register
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            q <= '0;
        end else if (load) begin
            q <= bcd_clamp(d);
        end else if (en) begin
            if (dir) begin
                q <= (q == BCD_MAX) ? '0 : q + 4'd1;
            end else begin
                q <= (q == '0) ? BCD_MAX : q - 4'd1;
            end
        end
    end

    assign term_c = dir ? (q == BCD_MAX) : (q == '0);

endmodule

// File: rtl/bcd_timer_ctrl.sv
// Cascaded BCD up/down timer with IDLE/RUN/PAUSE/DONE control FSM.
// Ports:
//   clk, clr  : clock, asynchronous active-high reset
//   tick      : one-cycle count-step strobe
//   start     : start/resume request
//   stop      : pause/abort request
//   load      : load preset request
//   up        : direction sampled on IDLE->RUN (1 = up)
//   preset    : BCD preset, digit 0 in bits [3:0]
//   q         : registered BCD count
//   state     : FSM state (IDLE=0, RUN=1, PAUSE=2, DONE=3)
//   running   : high exactly while in RUN
//   done      : one-cycle pulse on entry to DONE
module bcd_timer_ctrl
    import bcd_timer_ctrl_pkg::*;
#(
    parameter int unsigned NDIG = 4
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  tick,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  load,
    input  logic                  up,
    input  logic [BCD_W*NDIG-1:0] preset,
    output logic [BCD_W*NDIG-1:0] q,
    output logic [1:0]            state,
    output logic                  running,
    output logic                  done
);

    localparam int unsigned QW = BCD_W * NDIG;

    state_t          state_q;
    state_t          state_d;
    logic            dir_q;
    logic            running_q;
    logic            done_q;
    logic            step_c;
    logic            load_c;
    logic            dir_ld_c;
    logic            start_term_c;
    logic            hit_term_c;
    logic            carry_c;
    logic [NDIG-1:0] en_c;
    logic [NDIG-1:0] term_c;
    logic [QW-1:0]   q_bus;

    // State, direction and registered status outputs
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q   <= ST_IDLE;
            dir_q     <= 1'b1;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            running_q <= (state_d == ST_RUN);
            done_q    <= (state_d == ST_DONE) && (state_q != ST_DONE);
            if (dir_ld_c) begin
                dir_q <= up;
            end
        end
    end

    // Terminal detection: start_term_c checks the current count against the
    // terminal of the direction about to be latched; hit_term_c flags that
    // the next step lands on the terminal (RUN never sits on terminal).
    always_comb begin
        start_term_c = 1'b1;
        hit_term_c   = 1'b1;
        for (int unsigned i = 0; i < NDIG; i++) begin
            if (up) begin
                start_term_c &= (q_bus[i*BCD_W +: BCD_W] == BCD_MAX);
            end else begin
                start_term_c &= (q_bus[i*BCD_W +: BCD_W] == '0);
            end
            if (i == 0) begin
                hit_term_c &= dir_q ? (q_bus[BCD_W-1:0] == 4'd8)
                                    : (q_bus[BCD_W-1:0] == 4'd1);
            end else begin
                hit_term_c &= dir_q ? (q_bus[i*BCD_W +: BCD_W] == BCD_MAX)
                                    : (q_bus[i*BCD_W +: BCD_W] == '0);
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!load && start) begin
                    state_d = start_term_c ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_PAUSE;
                end else if (tick && hit_term_c) begin
                    state_d = ST_DONE;
                end
            end
            ST_PAUSE: begin
                if (load || stop) begin
                    state_d = ST_IDLE;
                end else if (start) begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                if (load || stop) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath controls
    always_comb begin
        load_c   = 1'b0;
        step_c   = 1'b0;
        dir_ld_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                load_c   = load;
                dir_ld_c = !load && start;
            end
            ST_RUN:   step_c = tick && !stop;
            ST_PAUSE: load_c = load;
            ST_DONE:  load_c = load;
            default:  load_c = 1'b0;
        endcase
    end

    // Ripple enable: digit i steps when all lower digits are at their terminal
    always_comb begin
        en_c    = '0;
        carry_c = step_c;
        for (int unsigned i = 0; i < NDIG; i++) begin
            en_c[i] = carry_c;
            carry_c = carry_c & term_c[i];
        end
    end

    for (genvar g = 0; g < NDIG; g++) begin : g_dig
        bcd_digit u_dig (
            .clk    (clk),
            .clr    (clr),
            .en     (en_c[g]),
            .dir    (dir_q),
            .load   (load_c),
            .d      (preset[g*BCD_W +: BCD_W]),
            .q      (q_bus[g*BCD_W +: BCD_W]),
            .term_c (term_c[g])
        );
    end

    assign q       = q_bus;
    assign state   = state_q;
    assign running = running_q;
    assign done    = done_q;

endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// Testbench for bcd_timer_ctrl (NDIG=4): directed vector table, hand-written
// multi-cycle sequences, and randomized stimulus against a decimal model.
module tb_bcd_timer_ctrl;

    localparam int NDIG = 4;
    localparam int MODV = 10000;

    logic        clk = 1'b0;
    logic        clr;
    logic        tick, start, stop, load, up;
    logic [15:0] preset;
    logic [15:0] q;
    logic [1:0]  state;
    logic        running, done;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: count held as a plain integer 0..9999
    int   m_val;
    int   m_state;
    logic m_dir;
    logic m_done;

    typedef struct {
        logic        tick, start, stop, load, up;
        logic [15:0] pr;
        logic [15:0] eq;
        logic [1:0]  es;
        logic        ed;
    } vec_t;

    vec_t vt[21];

    bcd_timer_ctrl #(.NDIG(NDIG)) dut (
        .clk     (clk),
        .clr     (clr),
        .tick    (tick),
        .start   (start),
        .stop    (stop),
        .load    (load),
        .up      (up),
        .preset  (preset),
        .q       (q),
        .state   (state),
        .running (running),
        .done    (done)
    );

    always #5 clk = ~clk;

    function automatic int clamp_val(logic [15:0] p);
        int v = 0;
        int w = 1;
        logic [3:0] d;
        for (int i = 0; i < NDIG; i++) begin
            d = p[i*4 +: 4];
            v += ((d > 4'd9) ? 9 : int'(d)) * w;
            w *= 10;
        end
        return v;
    endfunction

    function automatic logic [15:0] to_bcd(int v);
        logic [15:0] r = '0;
        int t = v;
        for (int i = 0; i < NDIG; i++) begin
            r[i*4 +: 4] = 4'(t % 10);
            t /= 10;
        end
        return r;
    endfunction

    function automatic int term_of(logic d);
        return d ? MODV - 1 : 0;
    endfunction

    function automatic vec_t mk(logic t, logic s, logic p, logic l, logic u,
                                logic [15:0] pr, logic [15:0] eq, logic [1:0] es, logic ed);
        vec_t v;
        v.tick = t; v.start = s; v.stop = p; v.load = l; v.up = u;
        v.pr = pr; v.eq = eq; v.es = es; v.ed = ed;
        return v;
    endfunction

    task automatic model_reset();
        m_val = 0; m_state = 0; m_dir = 1'b1; m_done = 1'b0;
    endtask

    task automatic model_clk(logic t, logic s, logic p, logic l, logic u, logic [15:0] pr);
        int old = m_state;
        case (m_state)
            0: begin
                if (l) m_val = clamp_val(pr);
                else if (s) begin
                    m_dir = u;
                    m_state = (m_val == term_of(u)) ? 3 : 1;
                end
            end
            1: begin
                if (p) m_state = 2;
                else if (t) begin
                    m_val = m_dir ? (m_val + 1) % MODV : (m_val + MODV - 1) % MODV;
                    if (m_val == term_of(m_dir)) m_state = 3;
                end
            end
            2: begin
                if (l) begin m_val = clamp_val(pr); m_state = 0; end
                else if (p) m_state = 0;
                else if (s) m_state = 1;
            end
            default: begin
                if (l) begin m_val = clamp_val(pr); m_state = 0; end
                else if (p) m_state = 0;
            end
        endcase
        m_done = (m_state == 3) && (old != 3);
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    endtask

    // Drive one cycle of inputs, wait past the edge, advance the model
    task automatic cyc(logic t, logic s, logic p, logic l, logic u, logic [15:0] pr);
        tick = t; start = s; stop = p; load = l; up = u; preset = pr;
        @(posedge clk);
        #1;
        model_clk(t, s, p, l, u, pr);
    endtask

    task automatic check_model(string tag);
        check({tag, ".q"},       32'(q),       32'(to_bcd(m_val)));
        check({tag, ".state"},   32'(state),   32'(m_state));
        check({tag, ".done"},    32'(done),    32'(m_done));
        check({tag, ".running"}, 32'(running), 32'(m_state == 1));
    endtask

    initial begin
        vt[0]  = mk(0,0,0,1,0, 16'h00A5, 16'h0095, 2'd0, 0);
        vt[1]  = mk(0,0,0,1,0, 16'h9999, 16'h9999, 2'd0, 0);
        vt[2]  = mk(0,1,0,0,1, 16'h0000, 16'h9999, 2'd3, 1);
        vt[3]  = mk(0,0,0,0,0, 16'h0000, 16'h9999, 2'd3, 0);
        vt[4]  = mk(1,1,0,0,0, 16'h0000, 16'h9999, 2'd3, 0);
        vt[5]  = mk(0,0,1,0,0, 16'h0000, 16'h9999, 2'd0, 0);
        vt[6]  = mk(0,0,0,1,0, 16'h0099, 16'h0099, 2'd0, 0);
        vt[7]  = mk(0,1,0,0,1, 16'h0000, 16'h0099, 2'd1, 0);
        vt[8]  = mk(1,0,0,0,0, 16'h0000, 16'h0100, 2'd1, 0);
        vt[9]  = mk(1,0,1,0,0, 16'h0000, 16'h0100, 2'd2, 0);
        vt[10] = mk(1,0,0,0,0, 16'h0000, 16'h0100, 2'd2, 0);
        vt[11] = mk(0,1,0,0,0, 16'h0000, 16'h0100, 2'd1, 0);
        vt[12] = mk(1,0,0,0,0, 16'h0000, 16'h0101, 2'd1, 0);
        vt[13] = mk(0,1,0,1,0, 16'h0000, 16'h0101, 2'd1, 0);
        vt[14] = mk(0,0,1,0,0, 16'h0000, 16'h0101, 2'd2, 0);
        vt[15] = mk(0,0,1,0,0, 16'h0000, 16'h0101, 2'd0, 0);
        vt[16] = mk(0,0,0,1,0, 16'h0100, 16'h0100, 2'd0, 0);
        vt[17] = mk(0,1,0,0,0, 16'h0000, 16'h0100, 2'd1, 0);
        vt[18] = mk(1,0,0,0,1, 16'h0000, 16'h0099, 2'd1, 0);
        vt[19] = mk(0,0,1,0,0, 16'h0000, 16'h0099, 2'd2, 0);
        vt[20] = mk(0,0,1,1,0, 16'h0012, 16'h0012, 2'd0, 0);

        clr = 1'b1; tick = 0; start = 0; stop = 0; load = 0; up = 0; preset = '0;
        model_reset();
        #1;
        check("reset.q",       32'(q),       32'h0);
        check("reset.state",   32'(state),   32'h0);
        check("reset.running", 32'(running), 32'h0);
        check("reset.done",    32'(done),    32'h0);
        @(posedge clk);
        #1;
        clr = 1'b0;

        // Directed table
        for (int i = 0; i < 21; i++) begin
            cyc(vt[i].tick, vt[i].start, vt[i].stop, vt[i].load, vt[i].up, vt[i].pr);
            check($sformatf("vec%0d.q", i),       32'(q),       32'(vt[i].eq));
            check($sformatf("vec%0d.state", i),   32'(state),   32'(vt[i].es));
            check($sformatf("vec%0d.done", i),    32'(done),    32'(vt[i].ed));
            check($sformatf("vec%0d.running", i), 32'(running), 32'(vt[i].es == 2'd1));
        end

        // Count 0012 down to terminal; done pulses once
        cyc(0,1,0,0,0, 16'h0);
        check("down12.start", 32'(state), 32'd1);
        for (int k = 1; k <= 11; k++) begin
            cyc(1,0,0,0,1, 16'h0);
            check($sformatf("down12.q%0d", k), 32'(q), 32'(to_bcd(12 - k)));
            check($sformatf("down12.done%0d", k), 32'(done), 32'd0);
        end
        cyc(1,0,0,0,1, 16'h0);
        check("down12.q_end",  32'(q),     32'h0000);
        check("down12.st_end", 32'(state), 32'd3);
        check("down12.pulse",  32'(done),  32'd1);
        cyc(0,0,0,0,0, 16'h0);
        check("down12.hold_st",   32'(state), 32'd3);
        check("down12.pulse_end", 32'(done),  32'd0);

        // DONE + load -> IDLE, then run to 0347 and clear mid-cycle
        cyc(0,0,0,1,0, 16'h0346);
        check("done_load.q",  32'(q),     32'h0346);
        check("done_load.st", 32'(state), 32'd0);
        cyc(0,1,0,0,1, 16'h0);
        cyc(1,0,0,0,0, 16'h0);
        check("pre_clr.q", 32'(q), 32'h0347);
        tick = 1'b1;
        #3;
        clr = 1'b1;
        #1;
        model_reset();
        check("clr.q",       32'(q),       32'h0);
        check("clr.state",   32'(state),   32'h0);
        check("clr.running", 32'(running), 32'h0);
        check("clr.done",    32'(done),    32'h0);
        @(posedge clk);
        #2;
        clr = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc(1,0,0,0,1, 16'h0);
            check_model($sformatf("post_clr%0d", k));
        end
        cyc(0,1,0,0,1, 16'h0);
        cyc(1,0,0,0,0, 16'h0);
        check("post_clr.step", 32'(q), 32'h0001);

        // Randomized run against the model
        for (int n = 0; n < 1500; n++) begin
            logic [15:0] pr;
            case ($urandom_range(0, 5))
                0: pr = 16'h9998;
                1: pr = 16'h0001;
                2: pr = 16'h9999;
                3: pr = 16'h0000;
                default: pr = 16'($urandom);
            endcase
            cyc(logic'($urandom_range(0, 1)),
                logic'($urandom_range(0, 3) == 0),
                logic'($urandom_range(0, 7) == 0),
                logic'($urandom_range(0, 7) == 0),
                logic'($urandom_range(0, 1)),
                pr);
            check_model($sformatf("rand%0d", n));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
